// File: rtl/agc_io_register_file_if.sv
// agc_io_register_file_if: CPU-side and input-channel signals of the AGC I/O register file.
// Latency: none (wires only).
// Backpressure: none; the register file accepts one write per cycle.
interface agc_io_register_file_if #(
    parameter int WIDTH = 15,
    parameter int SEL_W = 4
);
    logic [WIDTH-1:0] data_write;
    logic [SEL_W-1:0] sel_write;
    logic             en_write;
    logic [SEL_W-1:0] sel_read;
    logic [WIDTH-1:0] data_read;

    logic [WIDTH-1:0] data_DSKY_VERB;
    logic [WIDTH-1:0] data_DSKY_NOUN;
    logic [WIDTH-1:0] data_AXI_MISSION_TIME;
    logic [WIDTH-1:0] data_AXI_APOGEE;
    logic [WIDTH-1:0] data_AXI_PERIGEE;

    // CPU plus external sources drive everything except the read data.
    modport master (
        output data_write, sel_write, en_write, sel_read,
        output data_DSKY_VERB, data_DSKY_NOUN, data_AXI_MISSION_TIME,
        output data_AXI_APOGEE, data_AXI_PERIGEE,
        input  data_read
    );

    // The register file sees the mirror image.
    modport slave (
        input  data_write, sel_write, en_write, sel_read,
        input  data_DSKY_VERB, data_DSKY_NOUN, data_AXI_MISSION_TIME,
        input  data_AXI_APOGEE, data_AXI_PERIGEE,
        output data_read
    );
endinterface

// File: rtl/agc_io_register_file.sv
// agc_io_register_file: AGC I/O channels: ch0 null, ch1-5 sampled input shadows, ch6-15 CPU read/write registers.
// Latency: read is combinational from sel_read; writes and input samples become visible after the next rising edge.
// Backpressure: none, a write is taken every cycle. Macro IO_WRITE_BYPASS_EN forwards a same-cycle write on ch6-15 to the read port.
module agc_io_register_file #(
    parameter int WIDTH = 15,
    parameter int SEL_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    agc_io_register_file_if.slave bus
);
    localparam int NUM_CH   = 1 << SEL_W;
    localparam int NUM_SHD  = 5;
    localparam int FIRST_GP = NUM_SHD + 1;

    logic [WIDTH-1:0] src      [1:NUM_SHD];
    logic [WIDTH-1:0] shadow_q [1:NUM_SHD];
    logic [WIDTH-1:0] gp_q     [FIRST_GP:NUM_CH-1];
    logic             gp_wr    [FIRST_GP:NUM_CH-1];
    logic [WIDTH-1:0] stored_rd;

    // Shadow sources in channel order so the sampler is a simple loop.
    assign src[1] = bus.data_DSKY_VERB;
    assign src[2] = bus.data_DSKY_NOUN;
    assign src[3] = bus.data_AXI_MISSION_TIME;
    assign src[4] = bus.data_AXI_APOGEE;
    assign src[5] = bus.data_AXI_PERIGEE;

    // Write decode: only channels 6-15 have write enables, so writes to 0-5 fall on the floor.
    always_comb begin
        for (int i = FIRST_GP; i < NUM_CH; i++) begin
            gp_wr[i] = bus.en_write && (bus.sel_write == SEL_W'(i));
        end
    end

    // Input shadows resample their sources every edge; reset wins over sampling.
    always_ff @(posedge clock) begin
        for (int i = 1; i <= NUM_SHD; i++) begin
            if (reset) begin
                shadow_q[i] <= '0;
            end else begin
                shadow_q[i] <= src[i];
            end
        end
    end

    // General registers load on a decoded write and hold otherwise; reset wins over writes.
    always_ff @(posedge clock) begin
        for (int i = FIRST_GP; i < NUM_CH; i++) begin
            if (reset) begin
                gp_q[i] <= '0;
            end else if (gp_wr[i]) begin
                gp_q[i] <= bus.data_write;
            end
        end
    end

    // Read mux over stored state; channel 0 has no storage and reads zero.
    always_comb begin
        stored_rd = '0;
        for (int i = 1; i <= NUM_SHD; i++) begin
            if (bus.sel_read == SEL_W'(i)) begin
                stored_rd = shadow_q[i];
            end
        end
        for (int i = FIRST_GP; i < NUM_CH; i++) begin
            if (bus.sel_read == SEL_W'(i)) begin
                stored_rd = gp_q[i];
            end
        end
    end

`ifdef IO_WRITE_BYPASS_EN
    // Forward only when the write will really land: general channel, not in reset.
    logic bypass_hit;
    assign bypass_hit = !reset && bus.en_write
                        && (bus.sel_write == bus.sel_read)
                        && (bus.sel_write >= SEL_W'(FIRST_GP));
    assign bus.data_read = bypass_hit ? bus.data_write : stored_rd;
`else
    // Read-during-write returns the pre-write value.
    assign bus.data_read = stored_rd;
`endif

endmodule

// File: tb/tb_agc_io_register_file.sv
`timescale 1ns/1ps
module tb_agc_io_register_file;
    localparam int WIDTH = 15;
    localparam int SEL_W = 4;
`ifdef IO_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;

    agc_io_register_file_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    agc_io_register_file #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic [3:0]  sw;
        logic [14:0] dw;
        logic [3:0]  sr;
        logic [14:0] verb, noun, mtime, apo, peri;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    // Reference: one value per channel; channel 0 never changes.
    logic [14:0] mdl [16];

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] model_read();
        int sr;
        sr = int'(bus.sel_read);
        if (BYP && !reset && bus.en_write && bus.sel_write == bus.sel_read && sr >= 6)
            return bus.data_write;
        if (sr == 0) return 15'h0;
        return mdl[sr];
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 16; i++) mdl[i] = 15'h0;
        end else begin
            mdl[1] = bus.data_DSKY_VERB;
            mdl[2] = bus.data_DSKY_NOUN;
            mdl[3] = bus.data_AXI_MISSION_TIME;
            mdl[4] = bus.data_AXI_APOGEE;
            mdl[5] = bus.data_AXI_PERIGEE;
            if (bus.en_write && int'(bus.sel_write) >= 6)
                mdl[int'(bus.sel_write)] = bus.data_write;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input string name, input logic rst, input logic en,
                           input logic [3:0] sw, input logic [14:0] dw, input logic [3:0] sr,
                           input logic [14:0] verb, input logic [14:0] noun, input logic [14:0] mtime,
                           input logic [14:0] apo, input logic [14:0] peri, input logic [14:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.sw = sw; v.dw = dw; v.sr = sr;
        v.verb = verb; v.noun = noun; v.mtime = mtime; v.apo = apo; v.peri = peri;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        reset                     = v.rst;
        bus.en_write              = v.en;
        bus.sel_write             = v.sw;
        bus.data_write            = v.dw;
        bus.sel_read              = v.sr;
        bus.data_DSKY_VERB        = v.verb;
        bus.data_DSKY_NOUN        = v.noun;
        bus.data_AXI_MISSION_TIME = v.mtime;
        bus.data_AXI_APOGEE       = v.apo;
        bus.data_AXI_PERIGEE      = v.peri;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        logic [14:0] e;

        // Prelude: one reset edge with every input saturated.
        apply('{"pre", 1'b1, 1'b1, 4'hF, 15'h7FFF, 4'h0,
                15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h0});
        tick();

        // Reset held with saturated inputs: every channel reads 0.
        for (int s = 0; s < 16; s++)
            add_vec($sformatf("rst_sel%0d", s), 1'b1, 1'b1, 4'hF, 15'h7FFF, 4'(s),
                    15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h0);
        // Input sampling with one edge of latency.
        add_vec("noun_pre",  0, 0, 4'h0, 15'h0, 4'd2, 0, 15'h1234, 0, 0, 0, 15'h0000);
        add_vec("noun_1234", 0, 0, 4'h0, 15'h0, 4'd2, 0, 15'h1234, 0, 0, 0, 15'h1234);
        add_vec("noun_hold", 0, 0, 4'h0, 15'h0, 4'd2, 0, 15'h0042, 0, 0, 0, 15'h1234);
        add_vec("noun_0042", 0, 0, 4'h0, 15'h0, 4'd2, 0, 15'h0042, 0, 0, 0, 15'h0042);
        // Write then read.
        add_vec("wr9_same",  0, 1, 4'd9, 15'h5A5A, 4'd9, 0, 0, 0, 0, 0, BYP ? 15'h5A5A : 15'h0);
        add_vec("rd9",       0, 0, 4'd0, 15'h0,    4'd9, 0, 0, 0, 0, 0, 15'h5A5A);
        add_vec("rd8",       0, 0, 4'd0, 15'h0,    4'd8, 0, 0, 0, 0, 0, 15'h0000);
        // Protected channels.
        add_vec("wr0",       0, 1, 4'd0, 15'h7777, 4'd0, 0, 0, 0, 15'h0003, 0, 15'h0000);
        add_vec("wr4_same",  0, 1, 4'd4, 15'h7777, 4'd4, 0, 0, 0, 15'h0003, 0, 15'h0003);
        add_vec("rd4",       0, 0, 4'd0, 15'h0,    4'd4, 0, 0, 0, 15'h0003, 0, 15'h0003);
        add_vec("rd0",       0, 0, 4'd0, 15'h0,    4'd0, 0, 0, 0, 15'h0003, 0, 15'h0000);
        // Same-cycle read of write on channel 12.
        add_vec("wr12_init", 0, 1, 4'd12, 15'h0001, 4'd5,  0, 0, 0, 0, 0, 15'h0000);
        add_vec("wr12_same", 0, 1, 4'd12, 15'h0ABC, 4'd12, 0, 0, 0, 0, 0, BYP ? 15'h0ABC : 15'h0001);
        add_vec("rd12",      0, 0, 4'd0,  15'h0,    4'd12, 0, 0, 0, 0, 0, 15'h0ABC);
        // No forwarding on shadow channels.
        add_vec("wr3_same",  0, 1, 4'd3,  15'h1111, 4'd3,  0, 0, 0, 0, 0, 15'h0000);
        // Reset beats a simultaneous write and discards earlier writes.
        add_vec("wr15",      0, 1, 4'd15, 15'h2222, 4'd9,  0, 0, 0, 0, 0, 15'h5A5A);
        add_vec("rst_wr15",  1, 1, 4'd15, 15'h3FFF, 4'd15, 0, 0, 0, 0, 0, 15'h2222);
        add_vec("rd15_post", 0, 0, 4'd0,  15'h0,    4'd15, 0, 0, 0, 0, 0, 15'h0000);
        add_vec("rd9_post",  0, 0, 4'd0,  15'h0,    4'd9,  0, 0, 0, 0, 0, 15'h0000);
        add_vec("rd12_post", 0, 0, 4'd0,  15'h0,    4'd12, 0, 0, 0, 0, 0, 15'h0000);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            check(vecs[i].name, bus.data_read, vecs[i].exp);
            tick();
        end

        // Fill every general channel, then sweep the read port without clocking.
        reset = 1'b0;
        bus.data_DSKY_VERB        = 15'h0101;
        bus.data_DSKY_NOUN        = 15'h0102;
        bus.data_AXI_MISSION_TIME = 15'h0103;
        bus.data_AXI_APOGEE       = 15'h0104;
        bus.data_AXI_PERIGEE      = 15'h0105;
        for (int ch = 6; ch < 16; ch++) begin
            bus.en_write   = 1'b1;
            bus.sel_write  = 4'(ch);
            bus.data_write = 15'(ch * 'h111);
            tick();
        end
        bus.en_write = 1'b0;
        for (int ch = 0; ch < 16; ch++) begin
            bus.sel_read = 4'(ch);
            #1;
            if (ch == 0)     e = 15'h0;
            else if (ch < 6) e = 15'(15'h0100 + ch);
            else             e = 15'(ch * 'h111);
            check($sformatf("fill_ch%0d", ch), bus.data_read, e);
        end

        // Mid-sequence reset wipes everything, shadows refill one edge later.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int ch = 0; ch < 16; ch++) begin
            bus.sel_read = 4'(ch);
            #1;
            check($sformatf("wipe_ch%0d", ch), bus.data_read, 15'h0);
        end
        tick();
        for (int ch = 0; ch < 16; ch++) begin
            bus.sel_read = 4'(ch);
            #1;
            e = (ch >= 1 && ch <= 5) ? 15'(15'h0100 + ch) : 15'h0;
            check($sformatf("refill_ch%0d", ch), bus.data_read, e);
        end

        // Randomized traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            reset                     = ($urandom_range(63) == 0);
            bus.en_write              = $urandom_range(1);
            bus.sel_write             = 4'($urandom_range(15));
            bus.data_write            = 15'($urandom);
            bus.sel_read              = ($urandom_range(3) == 0) ? bus.sel_write : 4'($urandom_range(15));
            bus.data_DSKY_VERB        = 15'($urandom);
            bus.data_DSKY_NOUN        = 15'($urandom);
            bus.data_AXI_MISSION_TIME = 15'($urandom);
            bus.data_AXI_APOGEE       = 15'($urandom);
            bus.data_AXI_PERIGEE      = 15'($urandom);
            #1;
            check($sformatf("rand%0d_sel%0d", n, bus.sel_read), bus.data_read, model_read());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/agc_io_register_file.md
AGC_IO_REGISTER_FILE -- requirements
Module: agc_io_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 15, giving the channel data width in bits (AGC word).
REQ-002 SHALL have parameter SEL_W, default 4, giving the channel-select width (16 channels).
REQ-003 SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_write, input, WIDTH: write data from the CPU.
REQ-006 SHALL have port sel_write, input, SEL_W: channel to write.
REQ-007 SHALL have port en_write, input, 1 bit: write strobe.
REQ-008 SHALL have port sel_read, input, SEL_W: channel to read.
REQ-009 SHALL have port data_read, output, WIDTH: read data to the CPU.
REQ-010 SHALL have ports data_DSKY_VERB, data_DSKY_NOUN, data_AXI_MISSION_TIME, data_AXI_APOGEE and data_AXI_PERIGEE, each an input of WIDTH bits: external input-channel sources.

Function
REQ-011 SHALL use this channel map: 0 = null; 1 = DSKY_VERB; 2 = DSKY_NOUN; 3 = AXI_MISSION_TIME; 4 = AXI_APOGEE; 5 = AXI_PERIGEE; 6-15 = general read/write registers.
REQ-012 Channel 0 SHALL always read 0; writes to channel 0 SHALL be ignored.
REQ-013 Channels 1-5 SHALL be read-only shadow registers that capture their source input on every rising clock edge (1-cycle input latency).
REQ-014 Writes to channels 1-5 SHALL be ignored, with no effect on the shadow value.
REQ-015 Channels 6-15 SHALL load data_write on a rising edge when en_write=1 and sel_write selects that channel.
REQ-016 Channels 6-15 SHALL hold their value otherwise; at most one channel is written per cycle.
REQ-017 data_read SHALL be combinational from sel_read and the stored registers (zero-cycle read latency from sel_read).
REQ-018 Without bypass, read-during-write to the same channel SHALL return the pre-write value, and the new value SHALL appear the following cycle.
REQ-019 All channel data SHALL be exactly WIDTH bits, with no sign extension or arithmetic.
REQ-020 sel values SHALL decode fully; no value is illegal.
REQ-021 en_write=0 SHALL make sel_write and data_write don't-care.

Reset
REQ-022 While reset=1 at a rising edge, all channel registers 1-15 SHALL clear to 0.
REQ-023 reset SHALL take priority over a simultaneous write and over input sampling.
REQ-024 During and after reset, data_read SHALL equal the selected register, which is 0 until the first post-reset edge.
REQ-025 Reset asserted mid-sequence SHALL discard all prior writes.

Configuration
REQ-026 The macro IO_WRITE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-027 When IO_WRITE_BYPASS_EN is defined, and en_write=1 with sel_write==sel_read selecting a channel in 6-15, data_read SHALL equal data_write in the same cycle.
REQ-028 Bypass SHALL never apply to channels 0-5.
REQ-029 When IO_WRITE_BYPASS_EN is not defined, REQ-018 behaviour SHALL apply.

Verification
REQ-030 Reset scenario: hold reset=1 for 2 cycles with all inputs 15'h7FFF -> data_read=0 for every sel_read value during reset.
REQ-031 Input-sampling scenario: release reset, drive data_DSKY_NOUN=15'h1234 -> sel_read=2 reads 15'h1234 after one edge; change the input to 15'h0042 -> the read updates only after the next edge.
REQ-032 Write-then-read scenario: en_write=1, sel_write=9, data_write=15'h5A5A for one cycle -> sel_read=9 reads 15'h5A5A; sel_read=8 still reads 0.
REQ-033 Protected-channel scenario: write 15'h7777 to channel 0 and to channel 4 (data_AXI_APOGEE=15'h0003) -> channel 0 reads 0 and channel 4 reads 15'h0003.
REQ-034 Same-cycle read-of-write scenario: channel 12 holds 15'h0001, then write 15'h0ABC to channel 12 with sel_read=12 in the same cycle -> reads 15'h0001 without the macro, or 15'h0ABC with IO_WRITE_BYPASS_EN; reads 15'h0ABC next cycle in both builds.
REQ-035 Reset-versus-write scenario: reset=1 with a simultaneous write of 15'h3FFF to channel 15 -> channel 15 reads 0 after the edge.
